sdram_pattern_master: RTL

- Avalon-MM burst master sitting directly upstream of the SDRAM controller's Avalon slave port, in the SDRAM test design.
- On `start`, writes a region of SDRAM in fixed-length bursts with a known data pattern, then reads the region back in bursts.
- Compares every returned word against the regenerated pattern.
- Reports pass/fail, error count and first failing address to board-level status logic.

---
 rtl/sdram_pkg.sv | 29 ++
 rtl/sdram_pattern_gen.sv | 23 ++
 rtl/sdram_pattern_master.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared widths, burst-length constants, LFSR constants and FSM state encoding
// for the SDRAM pattern master.
package sdram_pkg;
  localparam int ADDR_W = 22;
  localparam int DATA_W = 16;
  localparam int BC_W   = 9;

  localparam int BURST_1   = 1;
  localparam int BURST_2   = 2;
  localparam int BURST_4   = 4;
  localparam int BURST_8   = 8;
  localparam int BURST_256 = 256;

  // Galois form of x^16+x^14+x^13+x^11+1 (right-shifting, taps in the high bits)
  localparam logic [DATA_W-1:0] LFSR_POLY = 16'hB400;
  localparam logic [DATA_W-1:0] LFSR_SEED = 16'hACE1;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_WR_BURST = 3'd1;
  localparam state_t S_RD_CMD   = 3'd2;
  localparam state_t S_RD_DATA  = 3'd3;
  localparam state_t S_FIN      = 3'd4;

  function automatic bit burst_is_legal(input int b);
    return (b == BURST_1) || (b == BURST_2) || (b == BURST_4) ||
           (b == BURST_8) || (b == BURST_256);
  endfunction
endpackage

// File: rtl/sdram_pattern_gen.sv
// Test-pattern source: incrementing counter, or a 16-bit Galois LFSR when
// SDRAM_PATTERN_LFSR_EN is defined. load restarts the sequence, advance steps it.
module sdram_pattern_gen
  import sdram_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  output logic [DATA_W-1:0] word
);
`ifdef SDRAM_PATTERN_LFSR_EN
  always_ff @(posedge clk) begin
    if (reset || load) word <= LFSR_SEED;
    else if (advance)  word <= word[0] ? ((word >> 1) ^ LFSR_POLY) : (word >> 1);
  end
`else
  always_ff @(posedge clk) begin
    if (reset || load) word <= '0;
    else if (advance)  word <= word + DATA_W'(1);
  end
`endif
endmodule

// File: rtl/sdram_pattern_master.sv
// Avalon-MM burst master: writes a region with a known pattern, reads it back,
// counts mismatches. Pattern selection via SDRAM_PATTERN_LFSR_EN (see sdram_pattern_gen).
module sdram_pattern_master
  import sdram_pkg::*;
#(
  parameter int                BURST      = 8,
  parameter int                NUM_BURSTS = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 22'h000000,
  parameter int                TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_writedata,
  output logic [BC_W-1:0]   m_burstcount,
  output logic [1:0]        m_byteenable,
  input  logic              m_waitrequest,
  input  logic              m_readdatavalid,
  input  logic [DATA_W-1:0] m_readdata
);
  localparam int              WD_W = $clog2(TIMEOUT + 1);
  localparam logic [BC_W-1:0] LAST = BC_W'(BURST - 1);
  localparam logic [16:0]     NB   = 17'(NUM_BURSTS);

  generate
    if (!burst_is_legal(BURST) || NUM_BURSTS < 1 || NUM_BURSTS > 65535) begin : g_bad_param
      $error("sdram_pattern_master: illegal BURST or NUM_BURSTS");
    end
  endgenerate

  state_t            state;
  logic [15:0]       k;
  logic [BC_W-1:0]   beat;
  logic [WD_W-1:0]   wdog;
  logic [DATA_W-1:0] pat_word;
  logic              pat_load, pat_adv;
  logic              start_ok, wr_xfer, rd_acc, rd_beat, last_k, wd_hit;

  function automatic logic [ADDR_W-1:0] burst_addr(input logic [15:0] kk);
    return BASE_ADDR + ADDR_W'(kk) * ADDR_W'(BURST);
  endfunction

  assign start_ok = start && (state == S_IDLE || state == S_FIN);
  assign wr_xfer  = (state == S_WR_BURST) && m_write && !m_waitrequest;
  assign rd_acc   = (state == S_RD_CMD) && m_read && !m_waitrequest;
  assign rd_beat  = (state == S_RD_CMD || state == S_RD_DATA) && m_readdatavalid;
  assign last_k   = ({1'b0, k} + 17'd1) == NB;
  assign wd_hit   = (state == S_WR_BURST || state == S_RD_CMD || state == S_RD_DATA) &&
                    !(wr_xfer || rd_acc || rd_beat) && (wdog == WD_W'(TIMEOUT - 1));

  // Reload at start and again when the last write beat lands, so reads regenerate word 0.
  assign pat_load = start_ok || (wr_xfer && beat == LAST && last_k);
  assign pat_adv  = wr_xfer || rd_beat;

  sdram_pattern_gen u_pat (
    .clk     (clk),
    .reset   (reset),
    .load    (pat_load),
    .advance (pat_adv),
    .word    (pat_word)
  );

  assign m_writedata  = m_write ? pat_word : '0;
  assign m_burstcount = BC_W'(BURST);
  assign m_byteenable = 2'b11;
  assign pass         = done && (err_count == 16'd0) && !timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE; k <= '0; beat <= '0; wdog <= '0;
      busy <= 1'b0; done <= 1'b0; timeout <= 1'b0;
      err_count <= '0; first_err_addr <= '0;
      m_read <= 1'b0; m_write <= 1'b0; m_address <= '0;
    end else begin
      if (rd_beat && m_readdata != pat_word) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (err_count == 16'd0)    first_err_addr <= m_address + ADDR_W'(beat);
      end
      if (wd_hit) begin
        timeout <= 1'b1; m_read <= 1'b0; m_write <= 1'b0;
        busy <= 1'b0; done <= 1'b1; wdog <= '0; state <= S_FIN;
      end else begin
        case (state)
          S_IDLE, S_FIN: if (start) begin
            state <= S_WR_BURST; k <= '0; beat <= '0; wdog <= '0;
            busy <= 1'b1; done <= 1'b0; timeout <= 1'b0;
            err_count <= '0; first_err_addr <= '0;
            m_write <= 1'b1; m_address <= BASE_ADDR;
          end
          S_WR_BURST: if (wr_xfer) begin
            wdog <= '0;
            if (beat == LAST) begin
              beat <= '0; m_write <= 1'b0;
              if (last_k) begin
                k <= '0; m_read <= 1'b1; m_address <= BASE_ADDR; state <= S_RD_CMD;
              end else begin
                k <= k + 16'd1; m_address <= burst_addr(k + 16'd1);
              end
            end else beat <= beat + BC_W'(1);
          end else begin
            wdog <= wdog + WD_W'(1);
            if (!m_write) m_write <= 1'b1;
          end
          S_RD_CMD: begin
            if (rd_beat) beat <= (beat == LAST) ? '0 : beat + BC_W'(1);
            if (rd_acc) begin
              m_read <= 1'b0; wdog <= '0; state <= S_RD_DATA;
            end else wdog <= rd_beat ? '0 : wdog + WD_W'(1);
          end
          S_RD_DATA: if (rd_beat) begin
            wdog <= '0;
            if (beat == LAST) begin
              beat <= '0;
              if (last_k) begin
                k <= '0; busy <= 1'b0; done <= 1'b1; state <= S_FIN;
              end else begin
                k <= k + 16'd1; m_address <= burst_addr(k + 16'd1);
                m_read <= 1'b1; state <= S_RD_CMD;
              end
            end else beat <= beat + BC_W'(1);
          end else wdog <= wdog + WD_W'(1);
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
